// File: rtl/display.sv
// display: two-digit seven-segment driver.
// Captures the 4-bit code {a,b,c,d} on a rising clock edge while ready is high.
// Shows the code as a decimal number 0..15: tens digit on dse, units digit on dsd.
// Segments are active-low (bit0 = seg a .. bit6 = seg g).
// Both digits are blank (7'h7F) until the first load after reset.
//
// Ports:
//   clk    - system clock, rising-edge active
//   reset  - asynchronous active-low reset
//   a..d   - code bits 3..0 (a is the MSB)
//   ready  - load strobe; code is sampled on clk rise while high
//   dse    - left display, tens digit, active-low segments
//   dsd    - right display, units digit, active-low segments
module display (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       ready,
    output logic [6:0] dse,
    output logic [6:0] dsd
);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [3:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       tens;
    logic [3:0] units;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] s;
        case (digit)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        if (ready) begin
            code_d  = {a, b, c, d};
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    // Decode from registers only, so the display follows the load edge
    // and blanks as soon as reset clears valid_q.
    always_comb begin
        tens  = 1'b0;
        units = code_q;
        if (code_q >= 4'd10) begin
            tens  = 1'b1;
            units = code_q - 4'd10;
        end
        if (valid_q) begin
            dse = seg7({3'b000, tens});
            dsd = seg7(units);
        end else begin
            dse = SEG_BLANK;
            dsd = SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_display.sv
module tb_display;

    logic       clk;
    logic       reset;
    logic       a, b, c, d;
    logic       ready;
    logic [6:0] dse, dsd;

    int unsigned checks;
    int unsigned errors;

    display dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .ready (ready),
        .dse   (dse),
        .dsd   (dsd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_pair(input string tag, input logic [6:0] exp_e, input logic [6:0] exp_d);
        check({tag, "_dse"}, dse, exp_e);
        check({tag, "_dsd"}, dsd, exp_d);
    endtask

    // Apply a code with ready for exactly one rising edge; returns at the
    // following falling edge so outputs are sampled away from the clock edge.
    task automatic load(input logic [3:0] v);
        @(negedge clk);
        {a, b, c, d} = v;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    logic [6:0] exp_e_tbl [16];
    logic [6:0] exp_d_tbl [16];

    initial begin
        checks = 0;
        errors = 0;
        exp_e_tbl = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40,
                      7'h40, 7'h40, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};
        exp_d_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                      7'h00, 7'h10, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};

        // 1. reset with no clock edge yet
        reset = 1'b0;
        ready = 1'b0;
        {a, b, c, d} = 4'b0101;
        #4;
        check_pair("reset_no_edge", 7'h7F, 7'h7F);

        // reset has priority over ready across an edge
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        check_pair("reset_over_ready", 7'h7F, 7'h7F);
        ready = 1'b0;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_pair("release_no_ready", 7'h7F, 7'h7F);

        // 2. first load
        load(4'b0001);
        check_pair("code1", 7'h40, 7'h79);

        // 3. boundary codes
        load(4'b1111);
        check_pair("code15", 7'h79, 7'h12);
        load(4'b1010);
        check_pair("code10", 7'h79, 7'h40);
        load(4'b1001);
        check_pair("code9", 7'h40, 7'h10);

        // 4. hold when ready is low
        load(4'b0111);
        check_pair("code7", 7'h40, 7'h78);
        {a, b, c, d} = 4'b0000;
        repeat (3) @(negedge clk);
        check_pair("hold7", 7'h40, 7'h78);

        // ready held high reloads every edge
        @(negedge clk);
        {a, b, c, d} = 4'b0011;
        ready = 1'b1;
        @(negedge clk);
        check_pair("held_ready_3", 7'h40, 7'h30);
        {a, b, c, d} = 4'b1101;
        @(negedge clk);
        check_pair("held_ready_13", 7'h79, 7'h30);
        ready = 1'b0;

        // 5. reset mid-cycle while showing 12
        load(4'b1100);
        check_pair("code12", 7'h79, 7'h24);
        #2;
        reset = 1'b0;
        #1;
        check_pair("reset_mid", 7'h7F, 7'h7F);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_pair("after_reset_blank", 7'h7F, 7'h7F);

        // 6. sweep all codes
        for (int i = 0; i < 16; i++) begin
            load(4'(i));
            check_pair($sformatf("sweep%0d", i), exp_e_tbl[i], exp_d_tbl[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
